// File: rtl/outwrctl_pkg.sv
// Shared types and default widths for the output write controller.
package outwrctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_BDBANKA = 15;
    localparam int DEF_BDBANKW = 64;
    localparam int DEF_BLEN    = 16;
    localparam int DEF_FIFOD   = 4;

endpackage

// File: rtl/outwrctl_if.sv
// Quantizer output stream plus data memory write port, bundled as one interface.
interface outwrctl_if #(
    parameter int AW = outwrctl_pkg::DEF_BDBANKA,
    parameter int DW = outwrctl_pkg::DEF_BDBANKW
);
    logic          qout_valid;
    logic [DW-1:0] qout_data;
    logic          qout_ready;
    logic          mem_grant;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    // master is the environment (quantizer + memory arbiter), slave is the controller
    modport master (
        output qout_valid, qout_data, mem_grant,
        input  qout_ready, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        input  qout_valid, qout_data, mem_grant,
        output qout_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/outwrctl_outfifo.sv
// Synchronous FIFO with registered storage; head is visible the cycle after a push.
module outwrctl_outfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty   = (wr_q == rd_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/outwrctl.sv
// Output write controller: buffers quantizer words and writes them to
// consecutive memory addresses from a per-job base, pulsing done at job end.
module outwrctl
    import outwrctl_pkg::*;
#(
    parameter int BDBANKA = DEF_BDBANKA,
    parameter int BDBANKW = DEF_BDBANKW,
    parameter int BLEN    = DEF_BLEN,
    parameter int FIFOD   = DEF_FIFOD
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [BDBANKA-1:0] baseaddr,
    input  logic [BLEN-1:0]    wlen,
    output logic               busy,
    output logic               done,
    outwrctl_if.slave          bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]         state_q, state_d;
    logic [BDBANKA-1:0] addr_q, addr_d;
    logic [BLEN-1:0]    wlen_q, wlen_d;
    logic [BLEN-1:0]    in_cnt_q, in_cnt_d;
    logic [BLEN-1:0]    out_cnt_q, out_cnt_d;

    logic               run;
    logic               ready;
    logic               we;
    logic               push;
    logic               commit;
    logic               fifo_full, fifo_empty;
    logic [BDBANKW-1:0] fifo_dout;

    assign run    = (state_q == ST_RUN);
    // ready ignores mem_grant so a same-cycle pop never opens a slot early
    assign ready  = run && !fifo_full && (in_cnt_q < wlen_q);
    assign we     = run && !fifo_empty;
    assign push   = bus.qout_valid && ready;
    assign commit = we && bus.mem_grant;

    assign bus.qout_ready = ready;
    assign bus.mem_we     = we;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = we ? fifo_dout : '0;
    assign busy           = run;
    assign done           = (state_q == ST_DONE);

    outwrctl_outfifo #(
        .DEPTH (FIFOD),
        .WIDTH (BDBANKW)
    ) u_fifo (
        .clk   (clk),
        .clr_n (clr_n),
        .push  (push),
        .pop   (commit),
        .din   (bus.qout_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wlen_d    = wlen_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (wlen != '0) begin
                        addr_d    = baseaddr;
                        wlen_d    = wlen;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        state_d   = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (push) in_cnt_d = in_cnt_q + BLEN'(1);
                if (commit) begin
                    addr_d    = addr_q + BDBANKA'(1);
                    out_cnt_d = out_cnt_q + BLEN'(1);
                    if (out_cnt_d == wlen_q) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wlen_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wlen_q    <= wlen_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end
endmodule

// File: tb/tb_outwrctl.sv
// Scoreboard bench for outwrctl: accepted words are queued as expected writes
// and matched against observed memory commits.
module tb_outwrctl;
    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [14:0] baseaddr;
    logic [15:0] wlen;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    outwrctl_if bus ();

    outwrctl dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .baseaddr (baseaddr),
        .wlen     (wlen),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    typedef struct {
        logic [14:0] addr;
        logic [63:0] data;
        int          cyc;
    } rec_t;

    rec_t        obs_q[$];
    rec_t        exp_q[$];
    logic [14:0] exp_addr;
    int          src_idx;
    int          cyc;
    int          acc_n, done_n, done_cyc, we_n, rdy_n;
    int          n_cmp, n_bad;

    function automatic logic [63:0] mkword(input int i);
        return {32'hD00D_0000 ^ 32'(i * 7), 32'(i)};
    endfunction

    // One clock: sample at negedge, record traffic, drive next word after posedge.
    task automatic step();
        rec_t r;
        @(negedge clk);
        cyc++;
        if (bus.mem_we && bus.mem_grant) begin
            r.addr = bus.mem_addr; r.data = bus.mem_wdata; r.cyc = cyc;
            obs_q.push_back(r);
        end
        if (bus.qout_valid && bus.qout_ready) begin
            r.addr = exp_addr; r.data = mkword(src_idx); r.cyc = cyc;
            exp_q.push_back(r);
            exp_addr = exp_addr + 15'd1;
            src_idx++;
            acc_n++;
        end
        if (done) begin done_n++; done_cyc = cyc; end
        if (bus.mem_we) we_n++;
        if (bus.qout_ready) rdy_n++;
        @(posedge clk);
        #1;
        bus.qout_data = mkword(src_idx);
    endtask

    task automatic start_job(input logic [14:0] base, input logic [15:0] len);
        start = 1'b1; baseaddr = base; wlen = len;
        exp_addr = base;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timeout);
        int d0;
        d0 = done_n;
        timeout = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_n != d0) begin timeout = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b1;
        #3 clr_n = 1'b0;
        #10;
        n_cmp++; if (bus.qout_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", bus.qout_ready); end
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", bus.mem_we); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
        n_cmp++; if (bus.mem_addr !== 15'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 64'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", bus.mem_wdata); end
        @(posedge clk);
        #1 clr_n = 1'b1;
    endtask

    task automatic test_stream();
        bit   to;
        int   s_cyc, first;
        rec_t o, e;
        bus.qout_valid = 1'b1; bus.mem_grant = 1'b1;
        start_job(15'h0100, 16'd8);
        s_cyc = cyc;
        wait_done(40, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL stream_timeout: got no done want done"); end
        n_cmp++; if (obs_q.size() != 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", obs_q.size()); end
        first = s_cyc + 2;
        for (int k = 0; k < 8 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.addr !== 15'h0100 + 15'(k)) begin n_bad++; $display("FAIL stream_addr[%0d]: got %h want %h", k, o.addr, 15'h0100 + 15'(k)); end
            n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", k, o.data, e.data); end
            n_cmp++; if (o.cyc != first + k) begin n_bad++; $display("FAIL stream_cycle[%0d]: got %0d want %0d", k, o.cyc, first + k); end
        end
        n_cmp++; if (done_cyc != first + 8) begin n_bad++; $display("FAIL stream_done_cyc: got %0d want %0d", done_cyc, first + 8); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stream_idle_busy: got %b want 0", busy); end
        bus.qout_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        bit   to;
        int   a0;
        rec_t o, e;
        a0 = acc_n;
        bus.qout_valid = 1'b1; bus.mem_grant = 1'b0;
        start_job(15'h0A00, 16'd6);
        for (int i = 0; i < 10; i++) step();
        n_cmp++; if (acc_n - a0 != 4) begin n_bad++; $display("FAIL bp_accepts: got %0d want 4", acc_n - a0); end
        n_cmp++; if (bus.qout_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b want 0", bus.qout_ready); end
        n_cmp++; if (bus.mem_we !== 1'b1) begin n_bad++; $display("FAIL bp_we: got %b want 1", bus.mem_we); end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL bp_early_writes: got %0d want 0", obs_q.size()); end
        bus.mem_grant = 1'b1;
        wait_done(40, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL bp_timeout: got no done want done"); end
        n_cmp++; if (obs_q.size() != 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", obs_q.size()); end
        for (int k = 0; k < 6 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.addr !== 15'h0A00 + 15'(k)) begin n_bad++; $display("FAIL bp_addr[%0d]: got %h want %h", k, o.addr, 15'h0A00 + 15'(k)); end
            n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want %h", k, o.data, e.data); end
        end
        bus.qout_valid = 1'b0;
    endtask

    task automatic test_wrap();
        bit          to;
        rec_t        o, e;
        logic [14:0] want [4];
        want[0] = 15'h7FFE; want[1] = 15'h7FFF; want[2] = 15'h0000; want[3] = 15'h0001;
        bus.qout_valid = 1'b1; bus.mem_grant = 1'b1;
        start_job(15'h7FFE, 16'd4);
        wait_done(30, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL wrap_timeout: got no done want done"); end
        n_cmp++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", obs_q.size()); end
        for (int k = 0; k < 4 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.addr !== want[k]) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, o.addr, want[k]); end
            n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL wrap_data[%0d]: got %h want %h", k, o.data, e.data); end
        end
        bus.qout_valid = 1'b0;
    endtask

    task automatic test_zero_len();
        int w0, r0, d0, s_cyc;
        w0 = we_n; r0 = rdy_n; d0 = done_n;
        bus.qout_valid = 1'b1; bus.mem_grant = 1'b1;
        start_job(15'h0055, 16'd0);
        s_cyc = cyc;
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (done_n - d0 != 1) begin n_bad++; $display("FAIL zero_done_count: got %0d want 1", done_n - d0); end
        n_cmp++; if (done_cyc != s_cyc + 1) begin n_bad++; $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc, s_cyc + 1); end
        n_cmp++; if (we_n != w0) begin n_bad++; $display("FAIL zero_we: got %0d cycles want 0", we_n - w0); end
        n_cmp++; if (rdy_n != r0) begin n_bad++; $display("FAIL zero_ready: got %0d cycles want 0", rdy_n - r0); end
        bus.qout_valid = 1'b0;
    endtask

    task automatic test_ignore_start();
        bit   to;
        int   a0, d0;
        rec_t o, e;
        a0 = acc_n; d0 = done_n;
        bus.qout_valid = 1'b1; bus.mem_grant = 1'b1;
        start_job(15'h0300, 16'd5);
        step();
        start = 1'b1; baseaddr = 15'h0200; wlen = 16'd9;
        step();
        start = 1'b0;
        wait_done(30, to);
        for (int i = 0; i < 4; i++) step();
        n_cmp++; if (to) begin n_bad++; $display("FAIL ign_timeout: got no done want done"); end
        n_cmp++; if (acc_n - a0 != 5) begin n_bad++; $display("FAIL ign_accepts: got %0d want 5", acc_n - a0); end
        n_cmp++; if (done_n - d0 != 1) begin n_bad++; $display("FAIL ign_done_count: got %0d want 1", done_n - d0); end
        n_cmp++; if (obs_q.size() != 5) begin n_bad++; $display("FAIL ign_count: got %0d want 5", obs_q.size()); end
        for (int k = 0; k < 5 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.addr !== 15'h0300 + 15'(k)) begin n_bad++; $display("FAIL ign_addr[%0d]: got %h want %h", k, o.addr, 15'h0300 + 15'(k)); end
            n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL ign_data[%0d]: got %h want %h", k, o.data, e.data); end
        end
        bus.qout_valid = 1'b0;
    endtask

    task automatic test_abort();
        bit   to;
        int   a0, d0;
        rec_t o, e;
        a0 = acc_n; d0 = done_n;
        bus.qout_valid = 1'b1; bus.mem_grant = 1'b0;
        start_job(15'h0040, 16'd8);
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (acc_n - a0 != 3) begin n_bad++; $display("FAIL abort_buffered: got %0d want 3", acc_n - a0); end
        #2 clr_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_we !== 1'b0) begin n_bad++; $display("FAIL abort_we: got %b want 0", bus.mem_we); end
        n_cmp++; if (bus.qout_ready !== 1'b0) begin n_bad++; $display("FAIL abort_ready: got %b want 0", bus.qout_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", done); end
        step();
        step();
        clr_n = 1'b1;
        n_cmp++; if (done_n != d0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses want 0", done_n - d0); end
        obs_q.delete();
        exp_q.delete();
        bus.mem_grant = 1'b1;
        start_job(15'h0010, 16'd2);
        wait_done(30, to);
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (to) begin n_bad++; $display("FAIL post_abort_timeout: got no done want done"); end
        n_cmp++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL post_abort_count: got %0d want 2", obs_q.size()); end
        for (int k = 0; k < 2 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.addr !== 15'h0010 + 15'(k)) begin n_bad++; $display("FAIL post_abort_addr[%0d]: got %h want %h", k, o.addr, 15'h0010 + 15'(k)); end
            n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL post_abort_data[%0d]: got %h want %h", k, o.data, e.data); end
        end
        bus.qout_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit   to1, to2;
        int   d0, s2;
        rec_t o, e;
        d0 = done_n;
        bus.qout_valid = 1'b1; bus.mem_grant = 1'b1;
        start_job(15'h0500, 16'd2);
        wait_done(20, to1);
        start_job(15'h0600, 16'd3);
        s2 = cyc;
        wait_done(20, to2);
        n_cmp++; if (to1 || to2) begin n_bad++; $display("FAIL b2b_timeout: got %b%b want 00", to1, to2); end
        n_cmp++; if (done_n - d0 != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_n - d0); end
        n_cmp++; if (obs_q.size() != 5) begin n_bad++; $display("FAIL b2b_count: got %0d want 5", obs_q.size()); end
        for (int k = 0; k < 5 && obs_q.size() > 0 && exp_q.size() > 0; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (o.addr !== ((k < 2) ? 15'h0500 + 15'(k) : 15'h0600 + 15'(k - 2))) begin
                n_bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", k, o.addr, (k < 2) ? 15'h0500 + 15'(k) : 15'h0600 + 15'(k - 2));
            end
            n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", k, o.data, e.data); end
            if (k == 2) begin
                n_cmp++; if (o.cyc != s2 + 2) begin n_bad++; $display("FAIL b2b_second_first_cyc: got %0d want %0d", o.cyc, s2 + 2); end
            end
        end
        bus.qout_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; src_idx = 0;
        acc_n = 0; done_n = 0; done_cyc = 0; we_n = 0; rdy_n = 0;
        exp_addr = '0;
        start = 1'b0; baseaddr = '0; wlen = '0;
        bus.qout_valid = 1'b0; bus.mem_grant = 1'b0;
        bus.qout_data = mkword(0);
        test_reset();
        step();
        test_stream();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/outwrctl.md
# outwrctl

Output write controller between the MVU quantizer output stream and the local data memory write port. It accepts quantized output words over a valid/ready handshake and buffers them in a small FIFO so quantizer progress is decoupled from memory-port arbitration. It issues one memory write per granted cycle at a self-incrementing address, starting from a per-job base address, and signals job completion.

## Interface
- BDBANKA, 15, data memory address width
- BDBANKW, 64, data memory word width
- BLEN, 16, width of the job word count
- FIFOD, 4, FIFO depth in words (power of two, at least 2)

- clk  in  1  clock, all logic on posedge
- clr_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job start pulse; sampled only in IDLE
- baseaddr  in  BDBANKA  first write address, captured on start
- wlen  in  BLEN  number of words in the job, captured on start
- qout_valid  in  1  quantizer word valid
- qout_data  in  BDBANKW  quantizer word
- qout_ready  out  1  controller accepts the word this cycle
- mem_grant  in  1  memory write port is available this cycle
- mem_we  out  1  write request
- mem_addr  out  BDBANKA  write address
- mem_wdata  out  BDBANKW  write data
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1, wlen>0: capture baseaddr into addr and wlen; clear in_cnt and out_cnt; go to RUN.
- IDLE, start=1, wlen=0: go to DONE; no writes occur.
- RUN:
  - qout_ready = FIFO not full AND in_cnt < wlen.
  - A push happens when qout_valid AND qout_ready; in_cnt increments.
  - mem_we = FIFO not empty. mem_wdata = FIFO head. mem_addr = addr.
  - A write commits when mem_we AND mem_grant: pop the FIFO, addr <= addr+1 (wraps modulo 2^BDBANKA), out_cnt increments.
  - When a commit makes out_cnt equal wlen, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. Words offered when in_cnt = wlen are not accepted (ready stays low).
- Push and pop in the same cycle are allowed. Occupancy is unchanged and both counters advance.
- mem_we, qout_ready and busy are 0 outside RUN. mem_addr holds its last value in IDLE and DONE.

## Timing
- Reset (clr_n low, asynchronous) forces:
  - IDLE;
  - FIFO empty;
  - addr, in_cnt, out_cnt = 0;
  - all outputs 0.
  - Reset mid-job aborts the job. Buffered words are discarded and no done pulse is produced.
- start in cycle N: busy=1 and addr valid from cycle N+1; qout_ready can be 1 in cycle N+1.
- Word pushed in cycle N appears at the FIFO head in cycle N+1 (registered FIFO), so its earliest commit is cycle N+1.
- Throughput: one word per cycle when qout_valid and mem_grant are held high.
- FIFO full: qout_ready=0 in the same cycle. A pop that cycle does not enable a push until the next cycle (ready does not depend on mem_grant).
- The last commit occurs in cycle N, done=1 in cycle N+1, and the block is in IDLE in cycle N+2. The earliest accepted new start is cycle N+2.
- Counters are BLEN bits; wlen = 2^BLEN-1 is legal.

## Structure
- Shared package:
  - state enum {IDLE, RUN, DONE};
  - default widths BDBANKA, BDBANKW, BLEN.
- Sub-module outfifo: synchronous FIFO, parameters depth and width.
  - Ports: push, pop, din, dout, full, empty.
  - Async active-low clear.
  - Pointers carry one extra wrap bit for full/empty detection.
- The top level holds the FSM, the address counter and the job counters.

## Test plan
- baseaddr=0x0100, wlen=8, qout_valid and mem_grant constantly 1 -> writes to 0x0100..0x0107 on 8 consecutive cycles with data in arrival order; done pulses once, one cycle after the last write.
- wlen=6, mem_grant=0 for 10 cycles then 1 -> qout_ready drops after 4 accepts; mem_we stays high; all 6 words are written in order once grant rises.
- baseaddr=0x7FFE, wlen=4 -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- start with wlen=0 -> done one cycle later; mem_we never asserted; qout_ready never asserted.
- Second start during RUN with baseaddr=0x0200 -> ignored; the original job completes unaffected. qout_valid held after 5 of wlen=5 accepted -> no sixth accept.
- clr_n pulsed low with 3 words buffered -> mem_we, qout_ready, busy and done drop to 0 immediately; a following job with wlen=2 writes exactly 2 words.
